// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates icache fetch and dcache load/store onto one single-ported RAM and
// returns registered one-cycle ihit/dhit pulses; a wait-state watchdog traps hung or faulted RAM.
module memory_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   input  logic [1:0]  ramstate,
   input  logic [31:0] ramload,
   output logic        ihit,
   output logic [31:0] iload,
   output logic        dhit,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   output logic        fault
);

   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {RAM_FREE = 2'd0, RAM_BUSY = 2'd1, RAM_ACCESS = 2'd2, RAM_ERROR = 2'd3} ramstate_t;
   typedef enum logic [1:0] {IDLE, DACC, IACC, HALT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic          timed_out;
   logic          ihit_q, ihit_d;
   logic          dhit_q, dhit_d;
   logic [31:0]   iload_q, iload_d;
   logic [31:0]   dload_q, dload_d;
   ramstate_t     rs;
   logic          d_req;

   assign rs        = ramstate_t'(ramstate);
   assign d_req     = dREN | dWEN;
   assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
   assign timed_out = (cnt_inc == CNT_MAX);

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ihit_d   = 1'b0;
      dhit_d   = 1'b0;
      iload_d  = iload_q;
      dload_d  = dload_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            // The requester still holds its request during the hit cycle; sit that cycle out.
            if (!(ihit_q || dhit_q)) begin
               if (d_req)     state_d = DACC;
               else if (iREN) state_d = IACC;
            end
         end
         DACC: begin
            ramREN   = dREN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (rs == RAM_ERROR)       state_d = HALT;
            else if (!d_req)           state_d = IDLE;
            else if (rs == RAM_ACCESS) begin
               state_d = IDLE;
               dhit_d  = 1'b1;
               if (dREN) dload_d = ramload;
            end else begin
               cnt_d = cnt_inc;
               if (timed_out) state_d = HALT;
            end
         end
         IACC: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (rs == RAM_ERROR)       state_d = HALT;
            else if (!iREN)            state_d = IDLE;
            else if (rs == RAM_ACCESS) begin
               state_d = IDLE;
               ihit_d  = 1'b1;
               iload_d = ramload;
            end else begin
               cnt_d = cnt_inc;
               if (timed_out) state_d = HALT;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ihit_q  <= 1'b0;
         dhit_q  <= 1'b0;
         iload_q <= '0;
         dload_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ihit_q  <= ihit_d;
         dhit_q  <= dhit_d;
         iload_q <= iload_d;
         dload_q <= dload_d;
      end
   end

   assign ihit  = ihit_q;
   assign dhit  = dhit_q;
   assign iload = iload_q;
   assign dload = dload_q;
   assign fault = (state_q == HALT);

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: transaction-level driver plus hit-queue scoreboard for memory_arbiter,
// covering priority, wait states, aborts, RAM errors, watchdog timeout and async reset.
module tb_memory_arbiter;

   localparam int TO = 4;

   localparam logic [1:0] RS_FREE   = 2'd0;
   localparam logic [1:0] RS_BUSY   = 2'd1;
   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   localparam int K_FETCH = 0;
   localparam int K_LOAD  = 1;
   localparam int K_STORE = 2;

   localparam int F_ACCESS = 0;
   localparam int F_ERROR  = 1;
   localparam int F_ABORT  = 2;
   localparam int F_RESET  = 3;

   logic        CLK, nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        ihit, dhit, ramREN, ramWEN, fault;
   logic [31:0] iload, dload, ramaddr, ramstore;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_iload = '0;
   logic [31:0] exp_dload = '0;

   memory_arbiter #(.TIMEOUT(TO)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .ramstate(ramstate), .ramload(ramload),
      .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .fault(fault)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // RAM bus expected while the arbiter is servicing the given kind of request.
   task automatic check_bus(input int kind);
      if (kind == K_FETCH) begin
         check_b("iacc_ren", ramREN, 1'b1);
         check_b("iacc_wen", ramWEN, 1'b0);
         check("iacc_addr", ramaddr, iaddr);
      end else begin
         check_b("dacc_ren", ramREN, dREN);
         check_b("dacc_wen", ramWEN, dWEN);
         check("dacc_addr", ramaddr, daddr);
         check("dacc_store", ramstore, dstore);
      end
   endtask

   task automatic check_quiet(input string tag);
      check_b({tag, "_ren"}, ramREN, 1'b0);
      check_b({tag, "_wen"}, ramWEN, 1'b0);
   endtask

   // Every hit must match the oldest outstanding completion the driver predicted.
   always @(negedge CLK) begin
      if (ihit || dhit) begin
         check_b("one_hit_only", ihit & dhit, 1'b0);
         if (exp_q.size() == 0) begin
            check("unexpected_hit", {30'b0, ihit, dhit}, 32'h0);
         end else begin
            mon_e = exp_q.pop_front();
            check("hit_kind", {30'b0, ihit, dhit}, mon_e.is_d ? 32'h1 : 32'h2);
            if (mon_e.is_d) check("dhit_dload", dload, mon_e.data);
            else            check("ihit_iload", iload, mon_e.data);
         end
      end
   end

   // One transaction, starting and ending on a falling edge. Outcome rules: a request is
   // accepted the cycle after it is seen in IDLE; each non-ACCESS cycle is a wait, and the
   // TO-th wait traps; ACCESS completes with a hit one cycle later, then one idle turnaround.
   task automatic run_txn(input int kind, input int waits, input int fin, input bit hold_i,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
      bit   halted = 1'b0;
      exp_t e;
      check("held_iload", iload, exp_iload);
      check("held_dload", dload, exp_dload);
      iREN = (kind == K_FETCH) || hold_i;
      dREN = (kind == K_LOAD);
      dWEN = (kind == K_STORE);
      if (kind == K_FETCH) iaddr = addr;
      else begin
         daddr  = addr;
         dstore = wdata;
      end
      ramstate = RS_FREE;
      #1 check_quiet("req_idle");
      @(posedge CLK); @(negedge CLK);

      for (int w = 0; w <= TO; w++) begin
         if (w == TO) begin
            halted = 1'b1;
            break;
         end
         if (w == waits) break;
         ramstate = ($urandom_range(0, 1) != 0) ? RS_BUSY : RS_FREE;
         #1 check_bus(kind);
         @(posedge CLK); @(negedge CLK);
      end

      if (!halted) begin
         case (fin)
            F_ACCESS: begin
               ramstate = RS_ACCESS;
               ramload  = rdata;
               #1 check_bus(kind);
               e.is_d = (kind != K_FETCH);
               if (kind == K_FETCH) exp_iload = rdata;
               if (kind == K_LOAD)  exp_dload = rdata;
               e.data = (kind == K_FETCH) ? exp_iload : exp_dload;
               exp_q.push_back(e);
               @(posedge CLK); @(negedge CLK);
               ramstate = RS_FREE;
               ramload  = $urandom;
               #1 check_quiet("hit_idle");
               @(posedge CLK); @(negedge CLK);
            end
            F_ERROR: begin
               ramstate = RS_ERROR;
               #1 check_bus(kind);
               @(posedge CLK); @(negedge CLK);
               halted = 1'b1;
            end
            F_ABORT: begin
               iREN = 1'b0;
               dREN = 1'b0;
               dWEN = 1'b0;
               #1 check_bus(kind);
               @(posedge CLK); @(negedge CLK);
               #1 check_quiet("abort_idle");
               @(negedge CLK);
            end
            default: begin
               ramstate = RS_BUSY;
               #1 nRST = 1'b0;
               iREN = 1'b0;
               dREN = 1'b0;
               dWEN = 1'b0;
               #1 check_quiet("rst_mid");
               check_b("rst_mid_ihit", ihit, 1'b0);
               check_b("rst_mid_dhit", dhit, 1'b0);
               check("rst_mid_dload", dload, 32'h0);
               exp_iload = '0;
               exp_dload = '0;
               #1 nRST = 1'b1;
               @(posedge CLK); @(negedge CLK);
            end
         endcase
      end

      if (halted) begin
         check_b("halt_fault", fault, 1'b1);
         check_quiet("halt");
         iREN     = 1'b1;
         dREN     = 1'b0;
         dWEN     = 1'b0;
         ramstate = RS_ACCESS;
         repeat (2) begin
            @(posedge CLK); @(negedge CLK);
            #1 check_b("halt_sticky", fault, 1'b1);
            check_quiet("halt_req");
         end
         nRST = 1'b0;
         iREN = 1'b0;
         ramstate = RS_FREE;
         #1 check_b("rst_fault", fault, 1'b0);
         check("rst_iload", iload, 32'h0);
         check("rst_dload", dload, 32'h0);
         exp_iload = '0;
         exp_dload = '0;
         #1 nRST = 1'b1;
         @(negedge CLK);
      end

      if (!hold_i) begin
         iREN = 1'b0;
         dREN = 1'b0;
         dWEN = 1'b0;
      end
   endtask

   initial begin
      int r, k;
      nRST = 1'b0;
      iREN = 1'b0;  dREN = 1'b0;  dWEN = 1'b0;
      iaddr = '0;   daddr = '0;   dstore = '0;
      ramstate = RS_FREE;
      ramload  = '0;
      repeat (2) @(negedge CLK);
      check_b("rst_ihit", ihit, 1'b0);
      check_b("rst_dhit", dhit, 1'b0);
      check("rst_iload0", iload, 32'h0);
      check("rst_dload0", dload, 32'h0);
      check_quiet("rst");
      check("rst_ramaddr", ramaddr, 32'h0);
      check("rst_ramstore", ramstore, 32'h0);
      check_b("rst_fault0", fault, 1'b0);
      nRST = 1'b1;
      @(negedge CLK);

      run_txn(K_FETCH, 0, F_ACCESS, 1'b0, 32'h0000_0040, 32'h0, 32'h2402_0001);
      run_txn(K_LOAD, 0, F_ACCESS, 1'b1, 32'h0000_0100, 32'h0, 32'h1234_5678);
      run_txn(K_FETCH, 0, F_ACCESS, 1'b0, 32'h0000_0044, 32'h0, 32'h0800_0010);
      run_txn(K_STORE, 3, F_ACCESS, 1'b0, 32'h0000_0080, 32'hDEAD_BEEF, 32'h5555_AAAA);
      run_txn(K_LOAD, TO, F_ACCESS, 1'b0, 32'h0000_0200, 32'h0, 32'h0);
      run_txn(K_FETCH, TO + 1, F_ACCESS, 1'b0, 32'h0000_0300, 32'h0, 32'h0);
      run_txn(K_FETCH, 1, F_ERROR, 1'b0, 32'h0000_0048, 32'h0, 32'h0);
      run_txn(K_LOAD, 0, F_ACCESS, 1'b0, 32'h0000_0104, 32'h0, 32'hCAFE_F00D);
      run_txn(K_LOAD, 1, F_RESET, 1'b0, 32'h0000_0108, 32'h0, 32'h0);
      run_txn(K_LOAD, 1, F_ABORT, 1'b0, 32'h0000_010C, 32'h0, 32'h0);
      run_txn(K_FETCH, 2, F_ABORT, 1'b0, 32'h0000_004C, 32'h0, 32'h0);

      for (int n = 0; n < 200; n++) begin
         r = int'($urandom_range(0, 19));
         k = int'($urandom_range(0, 2));
         if (r < 12)
            run_txn(k, int'($urandom_range(0, TO - 1)), F_ACCESS, 1'b0, $urandom, $urandom, $urandom);
         else if (r < 15) begin
            run_txn(int'($urandom_range(1, 2)), int'($urandom_range(0, TO - 1)), F_ACCESS, 1'b1,
                    $urandom, $urandom, $urandom);
            run_txn(K_FETCH, int'($urandom_range(0, TO - 1)), F_ACCESS, 1'b0, $urandom, $urandom, $urandom);
         end
         else if (r < 17)
            run_txn(k, int'($urandom_range(0, TO - 2)), F_ABORT, 1'b0, $urandom, $urandom, $urandom);
         else if (r == 17)
            run_txn(k, int'($urandom_range(0, TO - 1)), F_ERROR, 1'b0, $urandom, $urandom, $urandom);
         else if (r == 18)
            run_txn(k, TO + int'($urandom_range(0, 1)), F_ACCESS, 1'b0, $urandom, $urandom, $urandom);
         else
            run_txn(k, int'($urandom_range(0, TO - 2)), F_RESET, 1'b0, $urandom, $urandom, $urandom);
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end

      repeat (3) @(negedge CLK);
      check("pending_hits", exp_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
